// File: rtl/simple_frame_buffer.sv
// simple_frame_buffer
//   Buffers a valid-only word stream (no backpressure on the input side) in a
//   small first-word-fall-through FIFO and re-emits it on a valid/ready port.
//   Every FRAME_LEN-th delivered word is marked with dout_last. Input words
//   that arrive while the FIFO is full (and nothing pops that cycle) are
//   dropped and reported on a sticky overflow flag.
//
// Handshake: a word transfers on any cycle with dout_vld && dout_rdy (pop).
//   While dout_vld=1 and dout_rdy=0, dout/dout_last hold; dout_vld only
//   falls after a pop.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din_vld    in   input word valid (one word per cycle, no ready)
//   din        in   input word
//   dout_vld   out  output word valid
//   dout_rdy   in   downstream ready
//   dout       out  output word (0 when empty)
//   dout_last  out  final word of a frame, qualified by dout_vld
//   level      out  words held, 0..DEPTH, including the word on dout
//   overflow   out  sticky drop flag
//   ovf_clr    in   one-cycle pulse clearing overflow (a same-cycle drop wins)
module simple_frame_buffer #(
  parameter int WIDTH_DIN  = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_vld,
  input  logic [WIDTH_DIN-1:0]  din,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [WIDTH_DIN-1:0]  dout,
  output logic                  dout_last,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // A one-word frame still needs a 1-bit counter to keep the logic regular.
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  logic [WIDTH_DIN-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q,  level_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  ovf_q,    ovf_d;

  logic pop;
  logic wr_en;
  logic drop;
  logic at_last;

  assign dout_vld  = (level_q != '0);
  assign at_last   = (cnt_q == LAST_CNT);
  assign pop       = dout_vld && dout_rdy;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_en     = din_vld && ((level_q != FULL_LVL) || pop);
  assign drop      = din_vld && !wr_en;

  assign dout      = dout_vld ? mem_q[rd_ptr_q] : '0;
  assign dout_last = dout_vld && at_last;
  assign level     = level_q;
  assign overflow  = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      // Frame position follows delivered words only.
      cnt_d    = at_last ? '0 : cnt_q + CNT_ONE;
    end

    if (wr_en && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !wr_en) begin
      level_d = level_q - LVL_ONE;
    end

    // Set has priority over clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: level gates everything read from it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
